ca3_hash_ctrl: RTL and testbench
================================

# ca3_hash_ctrl

Sequencing controller for the gate-level hash round datapath built from `c1` logic cells and the `CA3_and_*` wrappers. It accepts message blocks over a valid/ready handshake and drives the datapath's state-load, init-select and round-enable strobes. It steps a round counter through every compression round and presents the digest over a valid/ready output handshake. It sits between the message input buffer and the hash datapath, and is the only sequential control in the hash core.

## Interface
- `ROUNDS`, default 16: compression rounds per message block; legal range 2..32.
- `IDX_W`, default 5: width of `round_idx`; must satisfy 2^IDX_W ≥ ROUNDS.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: a message block is present on the datapath inputs.
- `in_last` input 1: the presented block is the final block of the message; sampled with the handshake.
- `in_ready` output 1: controller can accept a block.
- `state_ld` output 1: one-cycle strobe; datapath loads its chaining register.
- `init_sel` output 1: with `state_ld`, selects the IV (1) or the previous chaining value (0).
- `round_en` output 1: datapath executes one round this cycle.
- `round_idx` output IDX_W: current round number, selects the round constant and message word.
- `out_valid` output 1: digest on the datapath outputs is final.
- `out_ready` input 1: consumer accepts the digest.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ROUND, OUT.
- Internal flags:
  - `first`: next block starts a new message.
  - `last_q`: the latched `in_last`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `last_q` ← `in_last` and go to LOAD.
- LOAD:
  - `state_ld`=1 and `init_sel`=`first` for one cycle.
  - Clear `round_idx` to 0 and go to ROUND.
- ROUND:
  - `round_en`=1 each cycle; `round_idx` increments by 1 per cycle.
  - At `round_idx`=ROUNDS−1, clear `first`.
  - Next state: OUT if `last_q`=1, otherwise IDLE.
- OUT:
  - Hold `out_valid`=1 until `out_ready`=1.
  - On `out_ready`: set `first`=1, clear `last_q`, go to IDLE.
  - Held `out_valid` never drops without `out_ready`.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Counter: `round_idx` is exactly IDX_W bits and never wraps within a block.
  - It saturates at ROUNDS−1 until the next LOAD.
  - Outside ROUND it holds its last value and is don't-care to the datapath.

## Timing
- Reset values:
  - State IDLE, `first`=1, `last_q`=0, `round_idx`=0.
  - `in_ready`=1; `state_ld`, `init_sel`, `round_en`, `out_valid`=0.
  - `busy`=0.
- Reset asserted mid-block or mid-OUT aborts immediately: outputs return to their reset values asynchronously, and the partial digest is discarded.
- Handshake at edge 0 → LOAD during cycle 1 → ROUND during cycles 2..ROUNDS+1.
- Last block: `out_valid` rises in cycle ROUNDS+2.
- Non-last block: `in_ready` returns in cycle ROUNDS+2, so block throughput is ROUNDS+2 cycles.
- `out_valid` and `out_ready` both high at an edge: the transfer completes and `in_ready`=1 in the next cycle.
- `in_valid` while not IDLE is ignored; the block upstream must hold it.
- `in_last` is sampled only at the accepting edge.

## Structure
- Shared package `ca3_hash_pkg` holds:
  - The FSM state enum `ca3_ctrl_state_t` (IDLE, LOAD, ROUND, OUT).
  - Default `CA3_ROUNDS` and `CA3_IDX_W` constants, also used by the datapath's constant ROM.
- One sub-module, `ca3_round_counter`:
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `idx` [IDX_W].
  - Output `term`: high when `idx`=ROUNDS−1.
  - The FSM uses `term` for the ROUND exit.

## Test plan
- Reset, then idle: `in_ready`=1, `busy`=0, all strobes 0 for 10 cycles.
- ROUNDS=4, single block with `in_last`=1:
  - `state_ld`=1 with `init_sel`=1 in cycle 1.
  - `round_en`=1 with `round_idx`=0,1,2,3 in cycles 2–5.
  - `out_valid`=1 in cycle 6.
- Two-block message (`in_last`=0 then 1), ROUNDS=4:
  - Second LOAD has `init_sel`=0.
  - `in_ready` is 0 throughout the first block, and the second block is accepted in cycle 6.
- Back-pressure: `out_ready` held 0 for 5 cycles.
  - `out_valid` stays 1 and `in_ready` stays 0.
  - `out_ready` pulse → IDLE next cycle, and the next block gets `init_sel`=1.
- `in_valid` asserted during ROUND: no second `state_ld` and no change to `round_idx` sequence.
- `rst` asserted at `round_idx`=2:
  - All outputs return to their reset values without waiting for a clock edge.
  - After release, a new block starts with `init_sel`=1.

Source files
------------

// File: rtl/ca3_hash_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ca3_hash_pkg
//  Purpose  : Shared types and default sizing for the CA3 hash core.
//  Revision : 1.0
// ============================================================================
package ca3_hash_pkg;

  // Default round count and round-index width, shared with the constant ROM.
  localparam int CA3_ROUNDS = 16;
  localparam int CA3_IDX_W  = 5;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } ca3_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/ca3_round_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ca3_round_counter
//  Purpose  : Round index counter; clears on request, advances when enabled,
//             and saturates at the final round of a block.
//  Revision : 1.0
// ============================================================================
module ca3_round_counter #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             term
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  // Final round reached; also blocks further increments so the index saturates.
  assign term = (idx == LAST_IDX);

  // Clear has priority over advance; increments stop at the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en && !term) begin
      idx <= idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ca3_hash_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ca3_hash_ctrl
//  Purpose  : Sequencing controller for the CA3 hash round datapath. Accepts
//             message blocks, drives load/init/round strobes and presents the
//             digest over a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
module ca3_hash_ctrl
  import ca3_hash_pkg::*;
#(
  parameter int ROUNDS = CA3_ROUNDS,
  parameter int IDX_W  = CA3_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             state_ld,
  output logic             init_sel,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  ca3_ctrl_state_t state;
  logic            first;   // next accepted block starts a new message
  logic            last_q;  // block in flight is the final one of its message
  logic            term;

  // The LOAD strobe doubles as the counter clear; rounds advance it.
  ca3_round_counter #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_round_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_ld),
    .en   (round_en),
    .idx  (round_idx),
    .term (term)
  );

  // Control FSM; every output is a register so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      first     <= 1'b1;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      state_ld  <= 1'b0;
      init_sel  <= 1'b0;
      round_en  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            last_q   <= in_last;
            state    <= LOAD;
            in_ready <= 1'b0;
            state_ld <= 1'b1;
            init_sel <= first;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state    <= ROUND;
          state_ld <= 1'b0;
          init_sel <= 1'b0;
          round_en <= 1'b1;
        end
        ROUND: begin
          if (term) begin
            first    <= 1'b0;
            round_en <= 1'b0;
            if (last_q) begin
              state     <= OUT;
              out_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            first     <= 1'b1;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ca3_hash_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ca3_hash_ctrl
//  Purpose  : Self-checking bench for ca3_hash_ctrl with ROUNDS=4.
//  Revision : 1.0
// ============================================================================
module tb_ca3_hash_ctrl;

  localparam int R  = 4;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, state_ld, init_sel, round_en, out_valid, busy;
  logic [IW-1:0] round_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  ca3_hash_ctrl #(.ROUNDS(R), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .state_ld  (state_ld),
    .init_sel  (init_sel),
    .round_en  (round_en),
    .round_idx (round_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a timeline counted from the accepting edge.
  // t=0 idle, t=1 load cycle, t=2..R+1 round cycles; mout = digest pending.
  int t     = 0;
  bit mout  = 0;
  bit mfirst = 1;
  bit mlast = 0;
  bit minit = 0;
  int midx  = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        t = 0; mout = 0; mfirst = 1; mlast = 0; minit = 0; midx = 0;
      end else if (mout) begin
        if (out_ready) begin
          mout = 0;
          mfirst = 1;
        end
      end else if (t == 0) begin
        if (in_valid) begin
          t = 1;
          mlast = in_last;
          minit = mfirst;
        end
      end else begin
        t = t + 1;
        if (t >= 2 && t <= R + 1) midx = t - 2;
        if (t == R + 2) begin
          t = 0;
          mfirst = 0;
          if (mlast) mout = 1;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on && !rst) begin
        chk("m_in_ready",  int'(in_ready),  int'(t == 0 && !mout));
        chk("m_state_ld",  int'(state_ld),  int'(t == 1));
        chk("m_init_sel",  int'(init_sel),  int'(t == 1 && minit));
        chk("m_round_en",  int'(round_en),  int'(t >= 2 && t <= R + 1));
        chk("m_round_idx", int'(round_idx), midx);
        chk("m_out_valid", int'(out_valid), int'(mout));
        chk("m_busy",      int'(busy),      int'(t != 0 || mout));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one block once the controller is ready; returns in the LOAD cycle.
  task automatic send(input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and idle.
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cmp_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_busy",     int'(busy), 0);
      chk("idle_strobes",  int'({state_ld, init_sel, round_en, out_valid}), 0);
      chk("idle_idx",      int'(round_idx), 0);
    end

    // Single last block, then back-pressure on the digest.
    send(1'b1);
    chk("b1_state_ld", int'(state_ld), 1);
    chk("b1_init_sel", int'(init_sel), 1);
    for (int k = 0; k < R; k++) begin
      cyc();
      chk("b1_round_en", int'(round_en), 1);
      chk("b1_round_idx", int'(round_idx), k);
    end
    cyc();
    chk("b1_out_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready",  int'(in_ready), 0);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_done_in_ready",  int'(in_ready), 1);
    chk("bp_done_out_valid", int'(out_valid), 0);

    // Two-block message; second block is held on in_valid during the rounds.
    send(1'b0);
    chk("m1_init_sel", int'(init_sel), 1);
    chk("m1_in_ready", int'(in_ready), 0);
    for (int k = 0; k < R; k++) begin
      cyc();
      chk("m1_round_idx", int'(round_idx), k);
      chk("m1_no_reload", int'(state_ld), 0);
      chk("m1_in_ready",  int'(in_ready), 0);
      in_valid = 1'b1;
      in_last  = 1'b1;
    end
    cyc();
    chk("m2_accept_in_ready", int'(in_ready), 1);
    chk("m2_out_valid",       int'(out_valid), 0);
    cyc();
    in_valid = 1'b0;
    chk("m2_state_ld", int'(state_ld), 1);
    chk("m2_init_sel", int'(init_sel), 0);
    repeat (R) cyc();
    cyc();
    chk("m2_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("m2_done_in_ready", int'(in_ready), 1);

    // Asynchronous reset in the middle of the rounds.
    send(1'b1);
    cyc();
    cyc();
    cyc();
    chk("ar_pre_idx", int'(round_idx), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_round_en",  int'(round_en), 0);
    chk("ar_round_idx", int'(round_idx), 0);
    chk("ar_in_ready",  int'(in_ready), 1);
    chk("ar_busy",      int'(busy), 0);
    chk("ar_strobes",   int'({state_ld, init_sel, out_valid}), 0);
    cyc();
    cyc();
    rst = 1'b0;
    send(1'b1);
    chk("ar_new_init_sel", int'(init_sel), 1);
    repeat (R + 1) cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_last   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (R + 4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
